// File: rtl/joy_filter.sv
// Joystick conditioning: tick-rate debounce, opposing-direction clean,
// fire-1 autofire and a held change-event handshake towards the CPU side.
module joy_filter #(
    parameter int PRESCALE = 50,
    parameter int DEBOUNCE = 4,
    parameter int AF_HALF  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  joy1,
    input  logic [7:0]  joy2,
    input  logic        af1,
    input  logic        af2,
    output logic [5:0]  out1,
    output logic [5:0]  out2,
    output logic        evValid,
    output logic [11:0] evData,
    output logic        evOvf,
    input  logic        evAck
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]    DB_LIMIT = 4'(DEBOUNCE);
    localparam logic [7:0]    AF_LAST  = 8'(AF_HALF - 1);

    logic [PW-1:0]    div_q, div_d;
    logic             tick;
    logic [11:0]      raw;
    logic [11:0]      stable_q, stable_d;
    logic [11:0][3:0] cnt_q, cnt_d;
    logic [7:0]       af_cnt_q, af_cnt_d;
    logic             phase_q, phase_d;
    logic [5:0]       out1_q, out1_d, out2_q, out2_d;
    logic [11:0]      prev_q;
    logic             ev_valid_q, ev_valid_d;
    logic [11:0]      ev_data_q, ev_data_d;
    logic             ev_ovf_q, ev_ovf_d;
    logic             change;
    logic             unused_hi;

    assign unused_hi = ^{joy1[7:6], joy2[7:6]};
    assign raw  = {joy2[5:0], joy1[5:0]};
    assign tick = (div_q == DIV_LAST);

    // Opposing pairs cancel to "neither"; fire1 is gated by the shared phase.
    function automatic logic [5:0] condition(input logic [5:0] s,
                                             input logic af, input logic ph);
        logic [5:0] r;
        r = s;
        if (s[0] && s[1]) r[1:0] = 2'b00;
        if (s[2] && s[3]) r[3:2] = 2'b00;
        if (af) r[4] = s[4] & ph;
        return r;
    endfunction

    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        af_cnt_d = af_cnt_q;
        phase_d  = phase_q;
        if (tick) begin
            for (int i = 0; i < 12; i++) begin
                if (raw[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
                    stable_d[i] = raw[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
            if (af_cnt_q == AF_LAST) begin
                af_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 8'd1;
            end
        end
        out1_d = condition(stable_q[5:0],  af1, phase_q);
        out2_d = condition(stable_q[11:6], af2, phase_q);
    end

    assign change = ({out2_q, out1_q} != prev_q);

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_data_d  = ev_data_q;
        ev_ovf_d   = ev_ovf_q;
        if (change) begin
            ev_data_d = {out2_q, out1_q};
            if (!ev_valid_q) begin
                ev_valid_d = 1'b1;
            end else if (evAck) begin
                ev_ovf_d = 1'b0;
            end else begin
                ev_ovf_d = 1'b1;
            end
        end else if (evAck && ev_valid_q) begin
            ev_valid_d = 1'b0;
            ev_ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            af_cnt_q   <= '0;
            phase_q    <= 1'b1;
            out1_q     <= '0;
            out2_q     <= '0;
            prev_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            ev_ovf_q   <= 1'b0;
        end else begin
            div_q      <= div_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            af_cnt_q   <= af_cnt_d;
            phase_q    <= phase_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            prev_q     <= {out2_q, out1_q};
            ev_valid_q <= ev_valid_d;
            ev_data_q  <= ev_data_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

    assign out1    = out1_q;
    assign out2    = out2_q;
    assign evValid = ev_valid_q;
    assign evData  = ev_data_q;
    assign evOvf   = ev_ovf_q;

endmodule

// File: doc/joy_filter.md
# joy_filter

Conditioning stage between the serial joystick reader and the CPU-visible joystick port. It takes the two raw 8-bit joystick words produced by the shift-register reader and registers them. It debounces every direction and fire line, resolves opposing directions, and applies optional autofire to fire 1. It also raises a held change-event handshake so the I/O decoder or interrupt logic can pick up new joystick states without polling.

## Interface
Parameters:
- PRESCALE, 50: clocks per sample tick; same rate as the reader's update strobe.
- DEBOUNCE, 4: consecutive differing ticks required before a filtered bit flips; range 1..15.
- AF_HALF, 8: sample ticks per autofire half-period; range 1..255.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- joy1  in  8  raw player 1: [0] right, [1] left, [2] down, [3] up, [4] fire1, [5] fire2, [7:6] ignored; 1 = pressed.
- joy2  in  8  raw player 2, same layout.
- af1  in  1  autofire enable, player 1 fire1.
- af2  in  1  autofire enable, player 2 fire1.
- out1  out  6  filtered player 1, same bit layout.
- out2  out  6  filtered player 2.
- evValid  out  1  change event pending.
- evData  out  12  {out2,out1} snapshot of the latest change.
- evOvf  out  1  one or more changes were merged while an event was pending.
- evAck  in  1  consumer acknowledge; effective only while evValid = 1.

## Operation
- Tick generator: counter 0..PRESCALE-1 wraps; tick = (counter == PRESCALE-1). Raw inputs are sampled only on the tick.
- Debounce: one stable register and one 4-bit counter per bit, 12 bits in total.
  - On a tick, if raw equals stable, the counter clears.
  - Otherwise the counter increments. When the incremented value equals DEBOUNCE, stable takes the raw value and the counter clears.
  - With DEBOUNCE = 1, stable follows raw on every tick.
- Opposing-direction clean, per player, on stable values: left and right both set gives both 0; up and down both set gives both 0.
- Autofire: one shared phase bit, reset to 1. A tick counter 0..AF_HALF-1 toggles the phase on wrap.
  - When afN = 1: fire1 out = stable fire1 AND phase.
  - When afN = 0: fire1 passes through.
  - Fire2 is never modified.
- Output registers: out1 and out2 take the cleaned and autofired values every clock.
- Event logic, with prev = {out2,out1} registered one clock behind:
  - A change is detected when {out2,out1} != prev.
  - Change with evValid = 0: evValid is set to 1 and evData takes {out2,out1}.
  - Change with evValid = 1 and no ack: evData takes the new value and evOvf is set to 1.
  - Change and evAck in the same clock: evData takes the new value, evValid stays 1, evOvf clears.
  - evAck with no change: evValid and evOvf clear.
  - evAck while evValid = 0 is ignored.
- Reset values: out1, out2, evData, prev = 0; evValid, evOvf = 0; tick counter, autofire counter and debounce counters = 0; stable = 0; phase = 1. Reset mid-debounce discards partial counts.

## Timing
- Press-to-output latency: the change is held through DEBOUNCE ticks. Stable updates on the clock of the DEBOUNCE-th tick, and out changes on the following clock.
- evValid rises one clock after out changes. evData is valid in the same cycle as evValid.
- A raw glitch shorter than DEBOUNCE ticks never reaches out.
- An autofire toggle every AF_HALF ticks produces out transitions and therefore events. This is intended.

## Test plan
- PRESCALE=4, DEBOUNCE=3. joy1 goes 0x00 to 0x08 and is held. Required: out1 = 0x08 exactly one clock after the 3rd tick; evValid = 1 the next clock with evData = 0x008.
- Same parameters. joy1 = 0x10 for 2 ticks, then 0x00. Required: out1 stays 0x00 and evValid stays 0.
- joy2 = 0x03 (left+right) held past debounce. Required: out2 = 0x00 and no event. Then joy2 = 0x02. Required: out2 = 0x02 after debounce.
- AF_HALF=2, af1=1, joy1 = 0x10 held. Required: out1 bit4 toggles every 2 ticks, starting at 1 after debounce. With af1=0, it stays 1.
- Two changes without ack. Required: evData holds the second value and evOvf = 1. Then pulse evAck for 1 clock. Required: evValid = 0 and evOvf = 0. A change coincident with evAck keeps evValid = 1 with the new data.
- Assert reset mid-debounce and mid-event. Required: all outputs are 0 immediately and asynchronously. After release, a new press needs a full DEBOUNCE ticks.
